// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks an active-low row, debounces a single-column hit
// and shifts each accepted hex code into a 32-bit value for the 8-digit display.
//
// state       | meaning
// ST_SCAN     | stepping rows once per tick, looking for exactly one low column
// ST_DEBOUNCE | row frozen, confirming the latched column pattern on successive ticks
// ST_HOLD     | press emitted, waiting for DEBOUNCE consecutive all-released ticks
module key_scan #(
   parameter logic [31:0] SCAN_DIV = 32'd50_000,
   parameter logic [7:0]  DEBOUNCE = 8'd4
) (
   input  logic        clkIn,
   input  logic        rst,
   input  logic [3:0]  col,
   input  logic        clr,
   output logic [3:0]  row,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] value
);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  col_m, col_s;
   logic [31:0] div;
   logic        tick;
   logic [1:0]  row_idx, row_idx_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [1:0]  r_lat, c_lat;
   logic [3:0]  lat_col;
   logic        latch, press;
   logic        col_hit;
   logic [1:0]  col_idx;
   logic [3:0]  press_code;

   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         col_m <= 4'hF;
         col_s <= 4'hF;
      end else begin
         col_m <= col;
         col_s <= col_m;
      end
   end

   assign tick = (div == SCAN_DIV - 32'd1);

   always_ff @(posedge clkIn or posedge rst) begin
      if (rst)       div <= 32'd0;
      else if (tick) div <= 32'd0;
      else           div <= div + 32'd1;
   end

   // Two or more low columns are ambiguous and treated the same as no key.
   always_comb begin
      col_hit = 1'b1;
      col_idx = 2'd0;
      case (col_s)
         4'hE:    col_idx = 2'd0;
         4'hD:    col_idx = 2'd1;
         4'hB:    col_idx = 2'd2;
         4'h7:    col_idx = 2'd3;
         default: col_hit = 1'b0;
      endcase
   end

   assign row        = ~(4'b0001 << row_idx);
   assign press_code = {r_lat, c_lat};

   always_comb begin
      state_nxt   = state;
      row_idx_nxt = row_idx;
      cnt_nxt     = cnt;
      latch       = 1'b0;
      press       = 1'b0;
      if (tick) begin
         case (state)
            ST_SCAN: begin
               if (col_hit) begin
                  latch     = 1'b1;
                  cnt_nxt   = 8'd0;
                  state_nxt = ST_DEBOUNCE;
               end else begin
                  row_idx_nxt = row_idx + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (col_s == lat_col) begin
                  if (cnt + 8'd1 == DEBOUNCE) begin
                     state_nxt = ST_HOLD;
                     cnt_nxt   = 8'd0;
                     press     = 1'b1;
                  end else begin
                     cnt_nxt = cnt + 8'd1;
                  end
               end else begin
                  state_nxt = ST_SCAN;
                  cnt_nxt   = 8'd0;
               end
            end
            ST_HOLD: begin
               if (col_s == 4'hF) begin
                  if (cnt + 8'd1 == DEBOUNCE) begin
                     state_nxt = ST_SCAN;
                     cnt_nxt   = 8'd0;
                  end else begin
                     cnt_nxt = cnt + 8'd1;
                  end
               end else begin
                  cnt_nxt = 8'd0;
               end
            end
            default: begin
               state_nxt = ST_SCAN;
               cnt_nxt   = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         state     <= ST_SCAN;
         row_idx   <= 2'd0;
         cnt       <= 8'd0;
         r_lat     <= 2'd0;
         c_lat     <= 2'd0;
         lat_col   <= 4'hF;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         value     <= 32'd0;
      end else begin
         state     <= state_nxt;
         row_idx   <= row_idx_nxt;
         cnt       <= cnt_nxt;
         key_valid <= press;
         if (latch) begin
            r_lat   <= row_idx;
            c_lat   <= col_idx;
            lat_col <= col_s;
         end
         if (press) key_code <= press_code;
         // A clear wins over a press landing on the same edge.
         if (clr)        value <= 32'd0;
         else if (press) value <= {value[27:0], press_code};
      end
   end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: emulates a 4x4 keypad on row/col and checks accepted codes
// against a queue-free model of the display value built from the keys pressed.
module tb_key_scan;

   logic        clkIn;
   logic        rst;
   logic [3:0]  col;
   logic        clr;
   logic [3:0]  row;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] value;

   logic [15:0] keys;
   logic [31:0] exp_value;
   int          checks;
   int          failures;
   int          pulses;
   int          p_start;
   logic [3:0]  row_tab [4];

   key_scan #(.SCAN_DIV(32'd4), .DEBOUNCE(8'd3)) dut (
      .clkIn     (clkIn),
      .rst       (rst),
      .col       (col),
      .clr       (clr),
      .row       (row),
      .key_valid (key_valid),
      .key_code  (key_code),
      .value     (value)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   // Keypad: key 4r+c shorts row r to column c.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
   end

   always @(posedge clkIn) begin
      #1;
      if (key_valid) pulses = pulses + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks = checks + 1;
      if (obs !== want) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
      end
   endtask

   task automatic wait_row_entry(input logic [3:0] target);
      int n;
      n = 0;
      while (row === target && n < 40) begin @(negedge clkIn); n++; end
      while (row !== target && n < 80) begin @(negedge clkIn); n++; end
      if (row !== target) check_val("row_wait", row, target);
   endtask

   task automatic press_wait(input int k);
      int n;
      n = 0;
      p_start = pulses;
      keys = 16'h0001 << k;
      while (pulses == p_start && n < 100) begin @(negedge clkIn); n++; end
      check_val("press_seen", pulses - p_start, 1);
      exp_value = {exp_value[27:0], k[3:0]};
      check_val("key_code", key_code, k);
      check_val("value", value, exp_value);
   endtask

   task automatic press_key(input int k, input int hold_after, input int gap);
      press_wait(k);
      repeat (hold_after) @(negedge clkIn);
      keys = 16'h0;
      repeat (gap) @(negedge clkIn);
      check_val("one_pulse", pulses - p_start, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, changes, p0, act, k;
      logic [3:0] prev;
      row_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
      checks = 0; failures = 0; pulses = 0; p_start = 0;
      keys = 16'h0; clr = 1'b0; rst = 1'b1; exp_value = 32'd0;

      repeat (3) @(negedge clkIn);
      check_val("rst_row", row, 4'hE);
      check_val("rst_value", value, 32'd0);
      check_val("rst_valid", key_valid, 1'b0);
      check_val("rst_code", key_code, 4'h0);
      rst = 1'b0;

      gap = 0; changes = 0; prev = row;
      for (int i = 0; i < 20; i++) begin
         @(negedge clkIn);
         gap++;
         if (row !== prev) begin
            changes++;
            check_val("row_seq", row, row_tab[changes % 4]);
            check_val("row_gap", gap, 4);
            gap = 0;
            prev = row;
         end
      end
      check_val("row_changes", changes, 5);

      // Clean press of key 6 from the moment row 1 is driven: pulse lands 4 ticks later.
      wait_row_entry(4'hD);
      p0 = pulses;
      keys = 16'h0001 << 6;
      repeat (15) @(negedge clkIn);
      check_val("latency_early", key_valid, 1'b0);
      @(negedge clkIn);
      check_val("latency", key_valid, 1'b1);
      check_val("clean_code", key_code, 4'h6);
      check_val("clean_value", value, 32'h0000_0006);
      @(negedge clkIn);
      check_val("pulse_width", key_valid, 1'b0);
      repeat (24) @(negedge clkIn);
      check_val("row_frozen", row, 4'hD);
      check_val("clean_pulses", pulses - p0, 1);
      keys = 16'h0;
      repeat (30) @(negedge clkIn);
      exp_value = 32'h0000_0006;

      wait_row_entry(4'hD);
      p0 = pulses;
      keys = 16'h0001 << 6;
      repeat (4) @(negedge clkIn);
      keys = 16'h0;
      repeat (6) @(negedge clkIn);
      check_val("bounce_freeze", row, 4'hD);
      repeat (3) @(negedge clkIn);
      check_val("bounce_resume", row, 4'hB);
      check_val("bounce_pulses", pulses - p0, 0);
      check_val("bounce_value", value, exp_value);

      @(negedge clkIn); clr = 1'b1;
      @(negedge clkIn); clr = 1'b0;
      exp_value = 32'd0;
      check_val("clr_value", value, exp_value);

      for (int i = 1; i <= 8; i++) press_key(i, 10, 30);
      press_key(15, 10, 30);
      check_val("wrap_value", value, 32'h2345_678F);

      press_wait(0);
      keys = keys | (16'h0001 << 5);
      repeat (40) @(negedge clkIn);
      check_val("second_key_ignored", pulses - p_start, 1);
      check_val("second_key_code", key_code, 4'h0);
      keys = 16'h0;
      repeat (30) @(negedge clkIn);
      press_key(5, 10, 30);

      // Clear lands on the same edge as the press of key 9.
      wait_row_entry(4'hB);
      p0 = pulses;
      keys = 16'h0001 << 9;
      repeat (15) @(negedge clkIn);
      clr = 1'b1;
      @(negedge clkIn);
      clr = 1'b0;
      check_val("clrpress_valid", key_valid, 1'b1);
      check_val("clrpress_code", key_code, 4'h9);
      check_val("clrpress_value", value, 32'd0);
      exp_value = 32'd0;
      repeat (10) @(negedge clkIn);
      keys = 16'h0;
      repeat (30) @(negedge clkIn);
      check_val("clrpress_pulses", pulses - p0, 1);
      press_key(3, 5, 30);

      wait_row_entry(4'h7);
      p0 = pulses;
      keys = 16'h0001 << 13;
      repeat (6) @(negedge clkIn);
      rst = 1'b1;
      #1;
      check_val("midrst_row", row, 4'hE);
      check_val("midrst_value", value, 32'd0);
      check_val("midrst_valid", key_valid, 1'b0);
      check_val("midrst_code", key_code, 4'h0);
      keys = 16'h0;
      repeat (2) @(negedge clkIn);
      rst = 1'b0;
      exp_value = 32'd0;
      repeat (40) @(negedge clkIn);
      check_val("midrst_pulses", pulses - p0, 0);

      for (int i = 0; i < 25; i++) begin
         act = $urandom_range(0, 9);
         k = $urandom_range(0, 15);
         if (act < 7) begin
            press_key(k, $urandom_range(0, 20), $urandom_range(25, 40));
         end else if (act < 9) begin
            p0 = pulses;
            keys = 16'h0001 << k;
            repeat ($urandom_range(1, 8)) @(negedge clkIn);
            keys = 16'h0;
            repeat (25) @(negedge clkIn);
            check_val("tap_reject", pulses - p0, 0);
         end else begin
            clr = 1'b1;
            @(negedge clkIn);
            clr = 1'b0;
            exp_value = 32'd0;
            check_val("rand_clr", value, exp_value);
         end
      end
      check_val("final_value", value, exp_value);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
